// File: rtl/game_sequencer_if.sv
// Bundle of key/event inputs and page/ball/status outputs between the game
// sequencer and the rest of the VGA ball game.
interface game_sequencer_if #(
  parameter int SCORE_W = 10
);
  logic               iSTART_KEY;
  logic               iPAUSE_KEY;
  logic               iFRAME_TICK;
  logic               iBALL_LOST;
  logic               iPADDLE_HIT;
  logic [1:0]         oPAGE;
  logic               oBALL_EN;
  logic               oBALL_SERVE;
  logic [2:0]         oLIVES;
  logic [SCORE_W-1:0] oSCORE;
  logic [1:0]         oSPEED;

  modport master (
    output iSTART_KEY, iPAUSE_KEY, iFRAME_TICK, iBALL_LOST, iPADDLE_HIT,
    input  oPAGE, oBALL_EN, oBALL_SERVE, oLIVES, oSCORE, oSPEED
  );

  modport slave (
    input  iSTART_KEY, iPAUSE_KEY, iFRAME_TICK, iBALL_LOST, iPADDLE_HIT,
    output oPAGE, oBALL_EN, oBALL_SERVE, oLIVES, oSCORE, oSPEED
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-level sequencer: start/serve/run/lost/over flow, lives, score and
// ball speed, with frame-based countdowns and a pause toggle during play.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 90,
  parameter int OVER_FRAMES  = 120,
  parameter int SCORE_W      = 10,
  parameter int SPEEDUP_HITS = 8,
  parameter int MAX_SPEED    = 3
) (
  input logic              iCLK,
  input logic              iRST_n,
  game_sequencer_if.slave  bus
);

  localparam int MAX_SL = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int MAXF   = (MAX_SL > OVER_FRAMES) ? MAX_SL : OVER_FRAMES;
  localparam int CNT_W  = $clog2(MAXF + 1);
  localparam int HIT_W  = $clog2(SPEEDUP_HITS + 1);

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_FRAMES);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES);
  localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(SPEEDUP_HITS);

  typedef enum logic [2:0] {IDLE, SERVE, RUN, LOST, OVER} state_t;

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [1:0] sat_inc_speed(input logic [1:0] v);
    return (v >= 2'(MAX_SPEED)) ? v : v + 2'd1;
  endfunction

  state_t             state, state_n;
  logic [CNT_W-1:0]   frame_cnt, frame_n, frame_inc;
  logic [HIT_W-1:0]   hit_cnt, hit_n, hit_inc;
  logic               pause_f, pause_n;
  logic [2:0]         lives, lives_n;
  logic [SCORE_W-1:0] score, score_n;
  logic [1:0]         speed, speed_n;
  logic [1:0]         page, page_n;
  logic               ball_en, ball_en_n;
  logic               ball_serve, ball_serve_n;
  logic               start_q, pause_q;
  logic               start_press, pause_press;

  assign start_press = bus.iSTART_KEY & ~start_q;
  assign pause_press = bus.iPAUSE_KEY & ~pause_q;
  assign frame_inc   = frame_cnt + CNT_W'(1);
  assign hit_inc     = hit_cnt + HIT_W'(1);

  always_comb begin
    state_n      = state;
    frame_n      = frame_cnt;
    hit_n        = hit_cnt;
    pause_n      = pause_f;
    lives_n      = lives;
    score_n      = score;
    speed_n      = speed;
    ball_serve_n = 1'b0;
    case (state)
      IDLE: if (start_press) begin
        lives_n = 3'(LIVES);
        score_n = '0;
        speed_n = '0;
        hit_n   = '0;
        frame_n = '0;
        state_n = SERVE;
      end
      SERVE: if (bus.iFRAME_TICK) begin
        if (frame_inc == SERVE_LAST) begin
          frame_n      = '0;
          ball_serve_n = 1'b1;
          state_n      = RUN;
        end else begin
          frame_n = frame_inc;
        end
      end
      RUN: begin
        if (pause_f) begin
          if (pause_press) pause_n = 1'b0;
        end else if (bus.iBALL_LOST) begin
          // A lost ball overrides any hit or pause press arriving with it.
          lives_n = lives - 3'd1;
          frame_n = '0;
          speed_n = '0;
          hit_n   = '0;
          state_n = LOST;
        end else begin
          if (pause_press) pause_n = 1'b1;
          if (bus.iPADDLE_HIT) begin
            score_n = sat_inc_score(score);
            if (hit_inc == HIT_LAST) begin
              speed_n = sat_inc_speed(speed);
              hit_n   = '0;
            end else begin
              hit_n = hit_inc;
            end
          end
        end
      end
      LOST: begin
        speed_n = '0;
        hit_n   = '0;
        if (bus.iFRAME_TICK) begin
          if (frame_inc == LOST_LAST) begin
            frame_n = '0;
            state_n = (lives == 3'd0) ? OVER : SERVE;
          end else begin
            frame_n = frame_inc;
          end
        end
      end
      OVER: begin
        if (bus.iFRAME_TICK && (frame_cnt != OVER_LAST)) frame_n = frame_inc;
        if (start_press && (frame_cnt == OVER_LAST)) begin
          frame_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != RUN) pause_n = 1'b0;

    // Outputs are registered from the next state so they change with it.
    case (state_n)
      IDLE:    page_n = 2'b00;
      RUN:     page_n = pause_n ? 2'b10 : 2'b01;
      OVER:    page_n = 2'b11;
      default: page_n = 2'b01;
    endcase
    ball_en_n = (state_n == RUN) && !pause_n;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      hit_cnt    <= '0;
      pause_f    <= 1'b0;
      lives      <= '0;
      score      <= '0;
      speed      <= '0;
      page       <= 2'b00;
      ball_en    <= 1'b0;
      ball_serve <= 1'b0;
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
    end else begin
      state      <= state_n;
      frame_cnt  <= frame_n;
      hit_cnt    <= hit_n;
      pause_f    <= pause_n;
      lives      <= lives_n;
      score      <= score_n;
      speed      <= speed_n;
      page       <= page_n;
      ball_en    <= ball_en_n;
      ball_serve <= ball_serve_n;
      start_q    <= bus.iSTART_KEY;
      pause_q    <= bus.iPAUSE_KEY;
    end
  end

  assign bus.oPAGE       = page;
  assign bus.oBALL_EN    = ball_en;
  assign bus.oBALL_SERVE = ball_serve;
  assign bus.oLIVES      = lives;
  assign bus.oSCORE      = score;
  assign bus.oSPEED      = speed;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a hit-sequence vector table plus hand-written
// multi-cycle sequences, checked through an expected-output queue.
module tb_game_sequencer;

  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;
  always #5 iCLK = ~iCLK;

  game_sequencer_if #(.SCORE_W(10)) bus();

  game_sequencer dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0] page;
    logic       en;
    logic       serve;
    logic [2:0] lives;
    logic [9:0] score;
    logic [1:0] speed;
  } out_t;

  typedef struct {
    int   start, pause, tick, lost, hit;
    out_t exp;
    out_t mask;
  } vec_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  out_t   exp_q[$];
  out_t   mask_q[$];
  string  name_q[$];
  vec_t   hits_tab[32];
  out_t   act, FM, NO_EN, NO_SP, DISP, Z;

  assign act = {bus.oPAGE, bus.oBALL_EN, bus.oBALL_SERVE, bus.oLIVES, bus.oSCORE, bus.oSPEED};

  function automatic out_t o(int pg, int en, int sv, int lv, int sc, int sp);
    out_t r;
    r.page  = 2'(pg);
    r.en    = (en != 0);
    r.serve = (sv != 0);
    r.lives = 3'(lv);
    r.score = 10'(sc);
    r.speed = 2'(sp);
    return r;
  endfunction

  task automatic apply(input int s, input int p, input int t, input int l, input int h,
                       input bit chk, input out_t e, input out_t m, input string nm);
    out_t  ee, mm;
    string n;
    bus.iSTART_KEY  = (s != 0);
    bus.iPAUSE_KEY  = (p != 0);
    bus.iFRAME_TICK = (t != 0);
    bus.iBALL_LOST  = (l != 0);
    bus.iPADDLE_HIT = (h != 0);
    if (chk) begin
      exp_q.push_back(e);
      mask_q.push_back(m);
      name_q.push_back(nm);
    end
    @(posedge iCLK);
    #1;
    if (chk) begin
      ee = exp_q.pop_front();
      mm = mask_q.pop_front();
      n  = name_q.pop_front();
      n_tests++;
      if ((act & mm) !== (ee & mm)) begin
        n_fail++;
        $display("FAIL %s: got page=%0d en=%0d serve=%0d lives=%0d score=%0d speed=%0d, want page=%0d en=%0d serve=%0d lives=%0d score=%0d speed=%0d (mask %h)",
                 n, act.page, act.en, act.serve, act.lives, act.score, act.speed,
                 ee.page, ee.en, ee.serve, ee.lives, ee.score, ee.speed, mm);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 1, 0, 0, 1'b0, Z, Z, "");
      apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");
    end
  endtask

  task automatic serve_and_run(input int lv, input int sc, input string tag);
    ticks(59);
    apply(0, 0, 0, 0, 0, 1'b1, o(1, 0, 0, lv, sc, 0), FM, {tag, "_tick59"});
    apply(0, 0, 1, 0, 0, 1'b1, o(1, 0, 1, lv, sc, 0), NO_EN, {tag, "_pulse"});
    apply(0, 0, 0, 0, 0, 1'b1, o(1, 1, 0, lv, sc, 0), FM, {tag, "_run"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Z     = '0;
    FM    = '1;
    NO_EN = FM; NO_EN.en = 1'b0;
    NO_SP = FM; NO_SP.speed = '0;
    DISP  = '0; DISP.page = '1; DISP.en = 1'b1; DISP.serve = 1'b1;

    for (int i = 0; i < 32; i++) begin
      int sp;
      sp = ((i + 1) / 8 > 3) ? 3 : (i + 1) / 8;
      hits_tab[i].start = 0;
      hits_tab[i].pause = 0;
      hits_tab[i].tick  = 0;
      hits_tab[i].lost  = 0;
      hits_tab[i].hit   = 1;
      hits_tab[i].exp   = o(1, 1, 0, 3, i + 1, sp);
      hits_tab[i].mask  = FM;
    end

    // Reset with start held: no press until it is released and pressed again.
    iRST_n = 1'b0;
    apply(1, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "reset");
    apply(1, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "reset_hold");
    iRST_n = 1'b1;
    apply(1, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "held_start_1");
    apply(1, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "held_start_2");
    apply(0, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "start_release");
    apply(1, 0, 0, 0, 0, 1'b1, o(1, 0, 0, 3, 0, 0), FM, "start_press");
    apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");

    // Pause in SERVE is ignored; RUN must come up unpaused.
    apply(0, 1, 0, 0, 0, 1'b1, o(1, 0, 0, 3, 0, 0), FM, "pause_in_serve");
    serve_and_run(3, 0, "serve1");

    for (int i = 0; i < 32; i++)
      apply(hits_tab[i].start, hits_tab[i].pause, hits_tab[i].tick, hits_tab[i].lost,
            hits_tab[i].hit, 1'b1, hits_tab[i].exp, hits_tab[i].mask, $sformatf("hit%0d", i + 1));

    apply(0, 0, 0, 1, 1, 1'b1, o(1, 0, 0, 2, 32, 0), NO_SP, "lost_and_hit");
    ticks(89);
    apply(0, 0, 0, 0, 0, 1'b1, o(1, 0, 0, 2, 32, 0), FM, "lost_tick89");
    apply(0, 0, 1, 0, 0, 1'b1, o(1, 0, 0, 2, 32, 0), FM, "lost_tick90");
    apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");
    serve_and_run(2, 32, "serve2");

    apply(0, 1, 0, 0, 0, 1'b1, o(2, 0, 0, 2, 32, 0), FM, "pause_on");
    apply(0, 0, 0, 0, 1, 1'b1, o(2, 0, 0, 2, 32, 0), FM, "hit_paused");
    apply(0, 0, 0, 1, 0, 1'b1, o(2, 0, 0, 2, 32, 0), FM, "lost_paused");
    apply(0, 1, 0, 0, 0, 1'b1, o(1, 1, 0, 2, 32, 0), FM, "pause_off");
    apply(0, 0, 0, 0, 1, 1'b1, o(1, 1, 0, 2, 33, 0), FM, "hit_after_pause");

    apply(0, 1, 0, 1, 0, 1'b1, o(1, 0, 0, 1, 33, 0), FM, "lost_beats_pause");
    ticks(90);
    serve_and_run(1, 33, "serve3");

    apply(0, 0, 0, 1, 0, 1'b1, o(1, 0, 0, 0, 33, 0), FM, "lost3");
    ticks(89);
    apply(0, 0, 1, 0, 0, 1'b1, o(3, 0, 0, 0, 33, 0), FM, "game_over");

    ticks(50);
    apply(1, 0, 0, 0, 0, 1'b1, o(3, 0, 0, 0, 33, 0), FM, "start_at_50");
    apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");
    ticks(69);
    apply(1, 0, 0, 0, 0, 1'b1, o(3, 0, 0, 0, 33, 0), FM, "start_at_119");
    apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");
    ticks(4);
    apply(1, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), DISP, "start_after_120");
    apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");
    apply(1, 0, 0, 0, 0, 1'b1, o(1, 0, 0, 3, 0, 0), FM, "restart");
    apply(0, 0, 0, 0, 0, 1'b0, Z, Z, "");

    ticks(10);
    iRST_n = 1'b0;
    apply(0, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "reset_mid_serve");
    iRST_n = 1'b1;
    ticks(70);
    apply(0, 0, 0, 0, 0, 1'b1, o(0, 0, 0, 0, 0, 0), FM, "idle_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
